// File: rtl/lcd_command_sequencer_if.sv
// Command request / byte stream handshake between the LCD text feed,
// the command sequencer and the SPI byte transmitter.
interface lcd_command_sequencer_if;
  logic         i_cmd_clear;
  logic         i_cmd_line1;
  logic         i_cmd_line2;
  logic [127:0] i_dat_line1;
  logic [127:0] i_dat_line2;
  logic         o_command_ready;
  logic [7:0]   o_tx_byte;
  logic         o_tx_valid;
  logic         o_tx_last;
  logic         i_tx_ready;

  modport slave (
    input  i_cmd_clear, i_cmd_line1, i_cmd_line2, i_dat_line1, i_dat_line2, i_tx_ready,
    output o_command_ready, o_tx_byte, o_tx_valid, o_tx_last
  );

  modport master (
    output i_cmd_clear, i_cmd_line1, i_cmd_line2, i_dat_line1, i_dat_line2, i_tx_ready,
    input  o_command_ready, o_tx_byte, o_tx_valid, o_tx_last
  );
endinterface

// File: rtl/lcd_command_sequencer.sv
// Turns single LCD commands (clear, line 1, line 2) into PMOD CLS escape
// sequences streamed one byte per accepted handshake toward the SPI driver.
module lcd_command_sequencer #(
  parameter int unsigned parm_hold_cycles = 40
) (
  input  logic                    i_clk_40mhz,
  input  logic                    i_rst_40mhz,
  lcd_command_sequencer_if.slave  bus
);

  localparam logic [7:0]  HOLD_LAST = 8'(parm_hold_cycles - 1);
  localparam logic [23:0] SEQ_CLEAR = 24'h1B5B6A;
  localparam logic [47:0] HDR_LINE1 = 48'h1B5B303B3048;
  localparam logic [47:0] HDR_LINE2 = 48'h1B5B313B3048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_HOLD
  } state_t;

  state_t       state;
  logic [175:0] shift_q;
  logic [4:0]   remaining;
  logic [7:0]   hold_cnt;

  // Non-printable characters would be interpreted by the display controller,
  // so they are replaced with spaces before being queued.
  function automatic logic [127:0] sanitize_text(input logic [127:0] txt);
    logic [127:0] res;
    logic [7:0]   c;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      c = txt[i*8 +: 8];
      res[i*8 +: 8] = ((c < 8'h20) || (c > 8'h7E)) ? 8'h20 : c;
    end
    return res;
  endfunction

  always_ff @(posedge i_clk_40mhz) begin
    if (i_rst_40mhz) begin
      state     <= ST_IDLE;
      shift_q   <= '0;
      remaining <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
          if (bus.i_cmd_clear) begin
            shift_q   <= {SEQ_CLEAR, 152'd0};
            remaining <= 5'd3;
            state     <= ST_SEND;
          end else if (bus.i_cmd_line1) begin
            shift_q   <= {HDR_LINE1, sanitize_text(bus.i_dat_line1)};
            remaining <= 5'd22;
            state     <= ST_SEND;
          end else if (bus.i_cmd_line2) begin
            shift_q   <= {HDR_LINE2, sanitize_text(bus.i_dat_line2)};
            remaining <= 5'd22;
            state     <= ST_SEND;
          end
        end
        // valid is constant in ST_SEND, so tx_ready alone marks a transfer
        ST_SEND: begin
          if (bus.i_tx_ready) begin
            if (remaining == 5'd1) begin
              shift_q   <= '0;
              remaining <= '0;
              state     <= ST_HOLD;
            end else begin
              shift_q   <= {shift_q[167:0], 8'h00};
              remaining <= remaining - 5'd1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_command_ready = (state == ST_IDLE);
  assign bus.o_tx_valid      = (state == ST_SEND);
  assign bus.o_tx_last       = (state == ST_SEND) && (remaining == 5'd1);
  assign bus.o_tx_byte       = shift_q[175:168];

endmodule
